// File: rtl/mips32_mem_dump_if.sv
// Memory read port and output word stream shared by the dump engine and its neighbours.
interface mips32_mem_dump_if #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 32
);
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rd_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [ADDR_W-1:0] out_addr;

   // Dump engine side: drives reads and the output stream.
   modport master (
      output mem_rd_en, mem_addr, out_valid, out_data, out_addr,
      input  mem_rd_data, out_ready
   );

   // Memory / consumer side.
   modport slave (
      input  mem_rd_en, mem_addr, out_valid, out_data, out_addr,
      output mem_rd_data, out_ready
   );
endinterface

// File: rtl/mips32_mem_dump.sv
// Post-HALT readback engine: reads a word range from memory and streams it out with a checksum.
module mips32_mem_dump #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 32
) (
   input  logic                clk1,
   input  logic                rst,
   input  logic                start,
   input  logic [ADDR_W-1:0]   base_addr,
   input  logic [ADDR_W:0]     count,
   input  logic                halted,
   mips32_mem_dump_if.master   bus,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [DATA_W-1:0]   checksum
);
   localparam int unsigned CNT_W = ADDR_W + 1;

   typedef enum logic [2:0] {
      IDLE, WAIT_HALT, READ, CAPTURE, OUT, FINISH
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0]  rem_q, rem_d;
   logic              mem_rd_en_q, mem_rd_en_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [ADDR_W-1:0] out_addr_q, out_addr_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] chk_q, chk_d;
   logic              active;

   // Next-state and next-output computation; registered outputs track the state being entered.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      rem_d       = rem_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_addr_d  = out_addr_q;
      err_d       = err_q;
      chk_d       = chk_q;
      mem_addr_d  = mem_addr_q;
      active      = (state_q == READ) || (state_q == CAPTURE) || (state_q == OUT);

      case (state_q)
         IDLE: begin
            if (start) begin
               ptr_d   = base_addr;
               rem_d   = count;
               chk_d   = '0;
               err_d   = 1'b0;
               state_d = (count == '0) ? FINISH : WAIT_HALT;
            end
         end
         WAIT_HALT: begin
            if (halted) state_d = READ;
         end
         READ: begin
            state_d = CAPTURE;
         end
         CAPTURE: begin
            out_data_d  = bus.mem_rd_data;
            out_addr_d  = ptr_q;
            out_valid_d = 1'b1;
            state_d     = OUT;
         end
         OUT: begin
            if (bus.out_ready) begin
               chk_d       = chk_q + out_data_q;
               ptr_d       = ptr_q + ADDR_W'(1);
               rem_d       = rem_q - CNT_W'(1);
               out_valid_d = 1'b0;
               state_d     = (rem_d != '0) ? READ : FINISH;
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Losing HALTED mid-dump aborts: keep what was delivered, flag it, and stop reading.
      if (active && !halted) begin
         state_d     = FINISH;
         err_d       = 1'b1;
         out_valid_d = 1'b0;
         ptr_d       = ptr_q;
         rem_d       = rem_q;
         chk_d       = chk_q;
         out_data_d  = out_data_q;
         out_addr_d  = out_addr_q;
      end

      mem_rd_en_d = (state_d == READ);
      if (mem_rd_en_d) mem_addr_d = ptr_d;
      busy_d = (state_d != IDLE);
      done_d = (state_d == FINISH);
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         rem_q       <= '0;
         mem_rd_en_q <= 1'b0;
         mem_addr_q  <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_addr_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         chk_q       <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         rem_q       <= rem_d;
         mem_rd_en_q <= mem_rd_en_d;
         mem_addr_q  <= mem_addr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_addr_q  <= out_addr_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         chk_q       <= chk_d;
      end
   end

   assign bus.mem_rd_en = mem_rd_en_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_addr  = out_addr_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign err           = err_q;
   assign checksum      = chk_q;
endmodule

// File: tb/tb_mips32_mem_dump.sv
// Directed bench for mips32_mem_dump with a one-cycle-latency memory model.
module tb_mips32_mem_dump;
   localparam int unsigned AW = 10;
   localparam int unsigned DW = 32;

   logic          clk1 = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   count;
   logic          halted;
   logic          busy, done, err;
   logic [DW-1:0] checksum;

   mips32_mem_dump_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mips32_mem_dump #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk1      (clk1),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .count     (count),
      .halted    (halted),
      .bus       (bus),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .checksum  (checksum)
   );

   always #5 clk1 = ~clk1;

   // Memory model: data valid the cycle after the read strobe.
   logic [DW-1:0] mem [0:1023];
   always @(posedge clk1) if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];

   // Consumer: ready held high, or cycling 1,0,0,1 under backpressure.
   logic       bp_mode = 1'b0;
   logic [1:0] bp_i = 2'd0;
   logic [3:0] bp_pat = 4'b1001;
   always @(negedge clk1) begin
      if (bp_mode) begin
         bus.out_ready = bp_pat[bp_i];
         bp_i = bp_i + 2'd1;
      end else begin
         bus.out_ready = 1'b1;
      end
   end

   // Monitor: delivered words, read strobes, done pulses, stall stability.
   logic [AW-1:0] wa_q[$];
   logic [DW-1:0] wd_q[$];
   int            rd_cnt = 0, done_cnt = 0, unstable = 0, stalls = 0;
   logic          held = 1'b0;
   logic [DW-1:0] hd;
   logic [AW-1:0] ha;
   always @(posedge clk1) begin
      if (bus.mem_rd_en) rd_cnt++;
      if (done) done_cnt++;
      if (held && bus.out_valid && (bus.out_data !== hd || bus.out_addr !== ha)) unstable++;
      if (bus.out_valid && bus.out_ready) begin
         wa_q.push_back(bus.out_addr);
         wd_q.push_back(bus.out_data);
      end
      held = bus.out_valid && !bus.out_ready;
      if (held) stalls++;
      hd = bus.out_data;
      ha = bus.out_addr;
   end

   int total = 0, bad = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_ctl"}, 64'({bus.mem_rd_en, bus.out_valid, busy, done, err, bus.mem_addr, bus.out_addr}), 64'd0);
      check({tag, "_dat"}, {bus.out_data, checksum}, 64'd0);
   endtask

   // Pulse start for one cycle; returns at the negedge after the accepting edge.
   task automatic start_dump(input logic [AW-1:0] b, input logic [AW:0] c);
      @(negedge clk1);
      start = 1'b1; base_addr = b; count = c;
      @(negedge clk1);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      while (busy && n < budget) begin
         @(negedge clk1);
         n++;
      end
      check(tag, 64'(busy), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0, d0, r0, u0, s0, n;
      rst = 1'b1; start = 1'b0; base_addr = '0; count = '0; halted = 1'b0;
      for (int i = 0; i < 1024; i++) mem[i] = '0;
      repeat (3) @(negedge clk1);
      check_reset_vals("rst_hold");
      rst = 1'b0;
      @(negedge clk1);
      check_reset_vals("rst_idle");

      // Factorial readback with latency checks.
      mem[198] = 32'd5040;
      halted = 1'b1;
      w0 = wa_q.size(); d0 = done_cnt;
      start_dump(10'd198, 11'd1);
      check("t1_busy", 64'(busy), 64'd1);
      check("t1_no_rd_yet", 64'(bus.mem_rd_en), 64'd0);
      @(negedge clk1);
      check("t1_rd", 64'({bus.mem_rd_en, bus.mem_addr}), 64'({1'b1, 10'd198}));
      @(negedge clk1);
      check("t1_rd_one_cycle", 64'({bus.mem_rd_en, bus.out_valid}), 64'd0);
      @(negedge clk1);
      check("t1_out", 64'({bus.out_valid, bus.out_addr, bus.out_data}), 64'({1'b1, 10'd198, 32'd5040}));
      @(negedge clk1);
      check("t1_done", 64'({done, bus.out_valid}), 64'({1'b1, 1'b0}));
      check("t1_chk", 64'(checksum), 64'd5040);
      wait_idle("t1_idle", 20);
      check("t1_done_cnt", 64'(done_cnt - d0), 64'd1);
      check("t1_words", 64'(wa_q.size() - w0), 64'd1);
      check("t1_word", 64'({wa_q[w0], wd_q[w0]}), 64'({10'd198, 32'd5040}));
      check("t1_err", 64'(err), 64'd0);

      // Multi-word with backpressure.
      for (int i = 0; i < 4; i++) mem[i] = DW'(i + 1);
      bp_mode = 1'b1;
      w0 = wa_q.size(); d0 = done_cnt; u0 = unstable; s0 = stalls;
      start_dump(10'd0, 11'd4);
      wait_idle("t2_idle", 200);
      bp_mode = 1'b0;
      check("t2_words", 64'(wa_q.size() - w0), 64'd4);
      for (int i = 0; i < 4; i++)
         if (wa_q.size() > w0 + i)
            check($sformatf("t2_word%0d", i), 64'({wa_q[w0+i], wd_q[w0+i]}), 64'({AW'(i), DW'(i + 1)}));
      check("t2_chk", 64'(checksum), 64'd10);
      check("t2_stalled", 64'(stalls > s0), 64'd1);
      check("t2_stable", 64'(unstable - u0), 64'd0);
      check("t2_done_cnt", 64'(done_cnt - d0), 64'd1);

      // Wrap-around from the top of memory.
      mem[1022] = 32'hA5A5_0001; mem[1023] = 32'h5A5A_0002; mem[0] = 32'hDEAD_0003;
      w0 = wa_q.size();
      start_dump(10'd1022, 11'd3);
      wait_idle("t3_idle", 100);
      check("t3_words", 64'(wa_q.size() - w0), 64'd3);
      if (wa_q.size() >= w0 + 3) begin
         check("t3_w0", 64'({wa_q[w0],   wd_q[w0]}),   64'({10'd1022, 32'hA5A5_0001}));
         check("t3_w1", 64'({wa_q[w0+1], wd_q[w0+1]}), 64'({10'd1023, 32'h5A5A_0002}));
         check("t3_w2", 64'({wa_q[w0+2], wd_q[w0+2]}), 64'({10'd0,    32'hDEAD_0003}));
      end
      check("t3_chk", 64'(checksum), 64'h0000_0000_DEAC_0006);

      // Wait for halt, then abort after the first word.
      for (int i = 0; i < 4; i++) mem[10 + i] = DW'(100 * (i + 1));
      halted = 1'b0;
      w0 = wa_q.size(); d0 = done_cnt; r0 = rd_cnt;
      start_dump(10'd10, 11'd4);
      repeat (10) @(negedge clk1);
      check("t4_no_rd", 64'(rd_cnt - r0), 64'd0);
      check("t4_waiting", 64'(busy), 64'd1);
      halted = 1'b1;
      n = 0;
      while (wa_q.size() == w0 && n < 50) begin
         @(negedge clk1);
         n++;
      end
      check("t4_first_word_timeout", 64'(wa_q.size() - w0), 64'd1);
      halted = 1'b0;
      wait_idle("t4_idle", 20);
      check("t4_words", 64'(wa_q.size() - w0), 64'd1);
      check("t4_err", 64'(err), 64'd1);
      check("t4_chk", 64'(checksum), 64'd100);
      check("t4_done_cnt", 64'(done_cnt - d0), 64'd1);

      // Zero count: done next cycle, no reads, err cleared by the start.
      halted = 1'b1;
      d0 = done_cnt; r0 = rd_cnt;
      start_dump(10'd5, 11'd0);
      check("t5_zero_done", 64'({done, err}), 64'({1'b1, 1'b0}));
      wait_idle("t5_zero_idle", 10);
      check("t5_zero_rd", 64'(rd_cnt - r0), 64'd0);
      check("t5_zero_done_cnt", 64'(done_cnt - d0), 64'd1);

      // Start pulse mid-dump is ignored.
      mem[100] = 32'd7; mem[101] = 32'd8; mem[102] = 32'd9; mem[500] = 32'd1000;
      w0 = wa_q.size(); d0 = done_cnt;
      start_dump(10'd100, 11'd3);
      repeat (2) @(negedge clk1);
      start_dump(10'd500, 11'd7);
      wait_idle("t5_idle", 100);
      check("t5_words", 64'(wa_q.size() - w0), 64'd3);
      for (int i = 0; i < 3; i++)
         if (wa_q.size() > w0 + i)
            check($sformatf("t5_word%0d", i), 64'({wa_q[w0+i], wd_q[w0+i]}), 64'({AW'(100 + i), DW'(7 + i)}));
      check("t5_chk", 64'(checksum), 64'd24);
      check("t5_done_cnt", 64'(done_cnt - d0), 64'd1);

      // Asynchronous reset while a word is on offer.
      mem[200] = 32'd77; mem[201] = 32'd88;
      start_dump(10'd200, 11'd2);
      n = 0;
      while (!bus.out_valid && n < 50) begin
         @(negedge clk1);
         n++;
      end
      check("t6_valid_seen", 64'(bus.out_valid), 64'd1);
      #2 rst = 1'b1;
      #1 check_reset_vals("t6_async");
      @(negedge clk1);
      rst = 1'b0;
      w0 = wa_q.size(); d0 = done_cnt;
      start_dump(10'd198, 11'd1);
      wait_idle("t6_idle", 50);
      check("t6_words", 64'(wa_q.size() - w0), 64'd1);
      if (wa_q.size() > w0)
         check("t6_word", 64'({wa_q[w0], wd_q[w0]}), 64'({10'd198, 32'd5040}));
      check("t6_chk", 64'(checksum), 64'd5040);
      check("t6_done_cnt", 64'(done_cnt - d0), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
